// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage: FSM state encoding, load
// funct3 codes and the "no destination register" marker used on the
// forwarding bus.
package writeback_stage_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COMMIT    = 2'd1,
    WAIT_LOAD = 2'd2
  } wb_state_t;

  // Load width / sign codes (funct3 of the load instruction)
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LD  = 3'b011;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_LWU = 3'b110;

  // Bit 5 set means "no register writeback"
  localparam logic [5:0] NO_RD = 6'h20;

endpackage

// File: rtl/writeback_stage_load_formatter.sv
// load_formatter: picks the addressed lane out of the aligned doubleword
// returned by the dcache, sign/zero-extends it per funct3, and flags a
// lane that is not aligned to the access width.
//   data       : aligned doubleword from the dcache
//   lane       : byte offset within the doubleword (address bits [2:0])
//   funct3     : load width/sign code (111 behaves as LD)
//   value      : extended load result
//   misaligned : access not naturally aligned
module load_formatter
  import writeback_stage_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  lane,
  input  logic [2:0]  funct3,
  output logic [63:0] value,
  output logic        misaligned
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] word_lane;

  always_comb begin
    byte_lane  = data[{lane, 3'b000} +: 8];
    half_lane  = data[{lane[2:1], 4'b0000} +: 16];
    word_lane  = data[{lane[2], 5'b00000} +: 32];
    value      = '0;
    misaligned = 1'b0;
    unique case (funct3)
      F3_LB:  value = {{56{byte_lane[7]}}, byte_lane};
      F3_LBU: value = {56'd0, byte_lane};
      F3_LH: begin
        value      = {{48{half_lane[15]}}, half_lane};
        misaligned = lane[0];
      end
      F3_LHU: begin
        value      = {48'd0, half_lane};
        misaligned = lane[0];
      end
      F3_LW: begin
        value      = {{32{word_lane[31]}}, word_lane};
        misaligned = |lane[1:0];
      end
      F3_LWU: begin
        value      = {32'd0, word_lane};
        misaligned = |lane[1:0];
      end
      default: begin
        value      = data;
        misaligned = |lane;
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: final pipeline stage. Captures the MEM/WB bundle, waits
// for outstanding dcache loads, formats load data, commits to the 32x64
// register file, serves the decode read ports with write-through bypass,
// and drives the WB->EX forwarding pair.
//   clk, reset           : clock, synchronous active-high reset
//   MEMWB_ready          : capture enable from the memory stage
//   memwb_*              : instruction bundle from the memory stage
//   load_str_done        : dcache load-complete strobe
//   id_rs1/2, id_rs1/2val: decode register read ports
//   WBEX_rd, WBEX_rdval  : forwarding pair (NO_RD when nothing commits)
//   WB_stall             : holds upstream stages while a load is pending
//   wb_misaligned        : one-cycle pulse on a misaligned load commit
//   retired              : count of committed instructions
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter logic [63:0] RESET_SP = 64'h0000_0000_0080_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEMWB_ready,
  input  logic [63:0] memwb_aluresult,
  input  logic [63:0] memwb_loadeddata,
  input  logic [5:0]  memwb_rd,
  input  logic        memwb_is_load,
  input  logic [2:0]  memwb_funct3,
  input  logic        load_str_done,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  output logic [63:0] id_rs1val,
  output logic [63:0] id_rs2val,
  output logic [5:0]  WBEX_rd,
  output logic [63:0] WBEX_rdval,
  output logic        WB_stall,
  output logic        wb_misaligned,
  output logic [63:0] retired
);

  wb_state_t   state, state_next;
  logic        capture;
  logic [63:0] s_alu;
  logic [63:0] s_data;
  logic [5:0]  s_rd;
  logic        s_is_load;
  logic [2:0]  s_funct3;
  logic [63:0] rf [32];

  logic [63:0] ld_value;
  logic        ld_mis;
  logic        in_commit;
  logic        mis_load;
  logic        wr_en;
  logic [4:0]  wr_idx;
  logic [63:0] wr_data;

  // WB_stall depends only on state, so capture has no combinational loop
  assign capture = MEMWB_ready && !WB_stall;

  load_formatter u_fmt (
    .data       (s_data),
    .lane       (s_alu[2:0]),
    .funct3     (s_funct3),
    .value      (ld_value),
    .misaligned (ld_mis)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic; a capture on the commit edge chains straight into the
  // next instruction without passing through IDLE
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, COMMIT: begin
        if (capture)
          state_next = (memwb_is_load && !load_str_done) ? WAIT_LOAD : COMMIT;
        else
          state_next = IDLE;
      end
      WAIT_LOAD: if (load_str_done) state_next = COMMIT;
      default:   state_next = IDLE;
    endcase
  end

  // Outputs and commit controls
  always_comb begin
    in_commit     = (state == COMMIT);
    WB_stall      = (state == WAIT_LOAD);
    mis_load      = s_is_load && ld_mis;
    wr_data       = s_is_load ? ld_value : s_alu;
    wr_idx        = s_rd[4:0];
    wr_en         = in_commit && !mis_load && !s_rd[5] && (s_rd[4:0] != 5'd0);
    wb_misaligned = in_commit && mis_load;
    WBEX_rd       = NO_RD;
    WBEX_rdval    = '0;
    if (in_commit && !mis_load) begin
      WBEX_rd    = s_rd;
      WBEX_rdval = wr_data;
    end
  end

  // Stage registers, register file and retire counter
  always_ff @(posedge clk) begin
    if (reset) begin
      s_alu     <= '0;
      s_data    <= '0;
      s_rd      <= '0;
      s_is_load <= 1'b0;
      s_funct3  <= '0;
      retired   <= '0;
      for (int unsigned i = 0; i < 32; i++) rf[i[4:0]] <= '0;
      rf[2]     <= RESET_SP;
    end else begin
      if (capture) begin
        s_alu     <= memwb_aluresult;
        s_rd      <= memwb_rd;
        s_is_load <= memwb_is_load;
        s_funct3  <= memwb_funct3;
        // Only meaningful if the load completes on this edge; otherwise it
        // is overwritten when load_str_done arrives in WAIT_LOAD
        s_data    <= memwb_loadeddata;
      end else if (WB_stall && load_str_done) begin
        s_data    <= memwb_loadeddata;
      end
      if (in_commit) retired <= retired + 64'd1;
      if (wr_en)     rf[wr_idx] <= wr_data;
    end
  end

  // Decode read ports with write-through of the value committing this cycle
  always_comb begin
    id_rs1val = rf[id_rs1];
    if (wr_en && (wr_idx == id_rs1)) id_rs1val = wr_data;
    if (id_rs1 == 5'd0)              id_rs1val = '0;
  end

  always_comb begin
    id_rs2val = rf[id_rs2];
    if (wr_en && (wr_idx == id_rs2)) id_rs2val = wr_data;
    if (id_rs2 == 5'd0)              id_rs2val = '0;
  end

endmodule
